// File: rtl/inta_sequencer_pkg.sv
// Shared definitions for the CPU-side interrupt-acknowledge sequencer.
//   state_e      : sequencer FSM states
//   CALL_OPCODE  : opcode an MCS-80 PIC must return on the first INTA_n pulse
//   PULSES_*     : INTA_n pulses per acknowledge sequence in each CPU mode
package inta_sequencer_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOW,
        GAP,
        COOLDOWN
    } state_e;

    localparam logic [7:0]  CALL_OPCODE  = 8'hCD;
    localparam int unsigned PULSES_8086  = 2;
    localparam int unsigned PULSES_MCS80 = 3;

endpackage

// File: rtl/inta_sequencer.sv
// CPU-side interrupt-acknowledge initiator for an 8259A environment.
// On INT with interrupts enabled it drives the INTA_n pulse train (2 pulses in
// 8086 mode, 3 in MCS-80 mode), samples the PIC data bus on the last cycle of
// every low phase, and presents the assembled vector / CALL instruction.
//
// Ports:
//   clock                    : system clock, rising edge
//   reset_n                  : asynchronous active-low reset
//   interrupt                : INT from the PIC
//   interrupt_enable         : CPU interrupt-enable flag
//   u8086_or_mcs80_config    : 1 = 8086 (2 pulses), 0 = MCS-80 (3 pulses)
//   data_bus_in[7:0]         : D7..D0 driven by the PIC while INTA_n is low
//   interrupt_acknowledge_n  : INTA_n to the PIC
//   busy                     : sequence in progress
//   vector_valid             : one-cycle strobe, results stable
//   vector_type[7:0]         : 8086 interrupt type (pulse-2 byte)
//   call_opcode[7:0]         : MCS-80 pulse-1 byte
//   call_address[15:0]       : MCS-80 {pulse-3 byte, pulse-2 byte}
//   opcode_error             : strobe with vector_valid when MCS-80 opcode != CALL
module inta_sequencer
    import inta_sequencer_pkg::*;
#(
    parameter int unsigned INTA_LOW_CYCLES = 2,
    parameter int unsigned INTA_GAP_CYCLES = 2
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        interrupt,
    input  logic        interrupt_enable,
    input  logic        u8086_or_mcs80_config,
    input  logic [7:0]  data_bus_in,
    output logic        interrupt_acknowledge_n,
    output logic        busy,
    output logic        vector_valid,
    output logic [7:0]  vector_type,
    output logic [7:0]  call_opcode,
    output logic [15:0] call_address,
    output logic        opcode_error
);

    localparam int unsigned MAX_CYCLES =
        (INTA_LOW_CYCLES > INTA_GAP_CYCLES) ? INTA_LOW_CYCLES : INTA_GAP_CYCLES;
    localparam int unsigned CW = $clog2(MAX_CYCLES + 1);

    localparam logic [CW-1:0] LOW_LAST = CW'(INTA_LOW_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST = CW'(INTA_GAP_CYCLES - 1);
    localparam logic [1:0]    LAST_IDX_8086  = 2'(PULSES_8086 - 1);
    localparam logic [1:0]    LAST_IDX_MCS80 = 2'(PULSES_MCS80 - 1);

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [1:0]      idx_q, idx_d;
    logic            mode_q, mode_d;       // 1 = 8086
    // Only pulse-1 and pulse-2 bytes need storage: the final byte is taken
    // straight from the bus into the result registers on its capture edge.
    logic [1:0][7:0] byte_q, byte_d;

    logic            inta_n_q, inta_n_d;
    logic            busy_q, busy_d;
    logic            valid_q, valid_d;
    logic            operr_q, operr_d;
    logic [7:0]      vtype_q, vtype_d;
    logic [7:0]      opcode_q, opcode_d;
    logic [15:0]     addr_q, addr_d;

    logic            start;
    logic [1:0]      last_idx;

    assign start    = interrupt & interrupt_enable;
    assign last_idx = mode_q ? LAST_IDX_8086 : LAST_IDX_MCS80;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        mode_d   = mode_q;
        byte_d   = byte_q;
        inta_n_d = 1'b1;
        busy_d   = busy_q;
        valid_d  = 1'b0;
        operr_d  = 1'b0;
        vtype_d  = vtype_q;
        opcode_d = opcode_q;
        addr_d   = addr_q;

        unique case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (start) begin
                    state_d  = LOW;
                    cnt_d    = '0;
                    idx_d    = '0;
                    mode_d   = u8086_or_mcs80_config;
                    inta_n_d = 1'b0;
                    busy_d   = 1'b1;
                end
            end

            LOW: begin
                if (cnt_q == LOW_LAST) begin
                    cnt_d = '0;
                    if (idx_q == 2'd0) byte_d[0] = data_bus_in;
                    if (idx_q == 2'd1) byte_d[1] = data_bus_in;
                    if (idx_q != last_idx) begin
                        state_d = GAP;
                        idx_d   = idx_q + 2'd1;
                    end else begin
                        state_d = COOLDOWN;
                        valid_d = 1'b1;
                        if (mode_q) begin
                            vtype_d = data_bus_in;
                        end else begin
                            opcode_d = byte_q[0];
                            addr_d   = {data_bus_in, byte_q[1]};
                            operr_d  = (byte_q[0] != CALL_OPCODE);
                        end
                    end
                end else begin
                    cnt_d    = cnt_q + CW'(1);
                    inta_n_d = 1'b0;
                end
            end

            GAP: begin
                if (cnt_q == GAP_LAST) begin
                    state_d  = LOW;
                    cnt_d    = '0;
                    inta_n_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            COOLDOWN: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d = '0;
                    // The cooldown-end edge doubles as the IDLE decision edge,
                    // so a held request restarts with no dead cycle in between.
                    if (start) begin
                        state_d  = LOW;
                        idx_d    = '0;
                        mode_d   = u8086_or_mcs80_config;
                        inta_n_d = 1'b0;
                    end else begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            mode_q   <= 1'b0;
            byte_q   <= '0;
            inta_n_q <= 1'b1;
            busy_q   <= 1'b0;
            valid_q  <= 1'b0;
            operr_q  <= 1'b0;
            vtype_q  <= '0;
            opcode_q <= '0;
            addr_q   <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            mode_q   <= mode_d;
            byte_q   <= byte_d;
            inta_n_q <= inta_n_d;
            busy_q   <= busy_d;
            valid_q  <= valid_d;
            operr_q  <= operr_d;
            vtype_q  <= vtype_d;
            opcode_q <= opcode_d;
            addr_q   <= addr_d;
        end
    end

    assign interrupt_acknowledge_n = inta_n_q;
    assign busy                    = busy_q;
    assign vector_valid            = valid_q;
    assign opcode_error            = operr_q;
    assign vector_type             = vtype_q;
    assign call_opcode             = opcode_q;
    assign call_address            = addr_q;

endmodule

// File: tb/tb_inta_sequencer.sv
// Scoreboard testbench for inta_sequencer. The driver issues acknowledge
// sequences, writes the expected per-cycle INTA_n/busy/strobe timeline into
// an associative array and pushes the expected result record into a queue;
// a negedge monitor compares the timeline and pops/compares on vector_valid.
module tb_inta_sequencer;

    localparam int unsigned L = 2;
    localparam int unsigned G = 2;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        interrupt;
    logic        interrupt_enable;
    logic        cfg;
    logic [7:0]  data_bus_in;
    logic        inta_n;
    logic        busy;
    logic        vector_valid;
    logic [7:0]  vector_type;
    logic [7:0]  call_opcode;
    logic [15:0] call_address;
    logic        opcode_error;

    inta_sequencer #(
        .INTA_LOW_CYCLES(L),
        .INTA_GAP_CYCLES(G)
    ) dut (
        .clock                   (clock),
        .reset_n                 (reset_n),
        .interrupt               (interrupt),
        .interrupt_enable        (interrupt_enable),
        .u8086_or_mcs80_config   (cfg),
        .data_bus_in             (data_bus_in),
        .interrupt_acknowledge_n (inta_n),
        .busy                    (busy),
        .vector_valid            (vector_valid),
        .vector_type             (vector_type),
        .call_opcode             (call_opcode),
        .call_address            (call_address),
        .opcode_error            (opcode_error)
    );

    always #5 clock = ~clock;

    int unsigned cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit inta;
        bit busy;
        bit valid;
        bit operr;
    } tl_t;

    typedef struct {
        logic [7:0]  vt;
        logic [7:0]  op;
        logic [15:0] addr;
        bit          operr;
        int unsigned at;
    } res_t;

    tl_t  tl[int unsigned];
    res_t resq[$];

    // Reference result registers, as the CPU should see them.
    logic [7:0]  m_vt   = 8'h00;
    logic [7:0]  m_op   = 8'h00;
    logic [15:0] m_addr = 16'h0000;

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endfunction

    always @(negedge clock) begin
        res_t r;
        if (tl.exists(cyc)) begin
            check("inta_n", 32'(inta_n), 32'(tl[cyc].inta));
            check("busy", 32'(busy), 32'(tl[cyc].busy));
            check("vector_valid", 32'(vector_valid), 32'(tl[cyc].valid));
            check("opcode_error", 32'(opcode_error), 32'(tl[cyc].operr));
        end
        if (vector_valid) begin
            if (resq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid cycle %0d: got strobe expected none", cyc);
            end else begin
                r = resq.pop_front();
                check("valid_cycle", cyc, r.at);
                check("vector_type", 32'(vector_type), 32'(r.vt));
                check("call_opcode", 32'(call_opcode), 32'(r.op));
                check("call_address", 32'(call_address), 32'(r.addr));
                check("opcode_err_at_valid", 32'(opcode_error), 32'(r.operr));
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int unsigned n, input bit intr, input bit en);
        for (int unsigned i = 0; i < n; i++) begin
            interrupt        = intr;
            interrupt_enable = en;
            cfg              = 1'($urandom);
            data_bus_in      = 8'($urandom);
            tick();
            tl[cyc] = '{inta: 1'b1, busy: 1'b0, valid: 1'b0, operr: 1'b0};
        end
    endtask

    // Issues one sequence; returns in its last cycle so the caller decides
    // whether the next start edge sees a request.
    task automatic run_seq(input bit m8086, input logic [7:0] b0, input logic [7:0] b1,
                           input logic [7:0] b2, input bit hammer);
        int unsigned p;
        int unsigned len;
        int unsigned vat;
        int unsigned e;
        logic [7:0]  bytes [3];
        bit          operr;
        res_t        r;
        p     = m8086 ? 2 : 3;
        len   = p * (L + G);
        vat   = p * L + (p - 1) * G;
        e     = cyc + 1;
        bytes = '{b0, b1, b2};
        operr = !m8086 && (b0 != 8'hCD);

        interrupt        = 1'b1;
        interrupt_enable = 1'b1;
        cfg              = m8086;
        data_bus_in      = 8'($urandom);

        for (int unsigned c = 0; c < len; c++) begin
            tl_t t;
            t.inta  = (c % (L + G)) >= L;
            t.busy  = 1'b1;
            t.valid = (c == vat);
            t.operr = (c == vat) && operr;
            tl[e + c] = t;
        end

        if (m8086) begin
            m_vt = b1;
        end else begin
            m_op   = b0;
            m_addr = {b2, b1};
        end
        r = '{vt: m_vt, op: m_op, addr: m_addr, operr: operr, at: e + vat};
        resq.push_back(r);

        for (int unsigned c = 0; c < len; c++) begin
            tick();
            if (c < len - 1) begin
                if (hammer) begin
                    interrupt        = 1'b1;
                    interrupt_enable = 1'b1;
                end else begin
                    interrupt        = 1'($urandom);
                    interrupt_enable = 1'($urandom);
                end
                cfg = 1'($urandom);
            end
            data_bus_in = ((c % (L + G)) == L - 1) ? bytes[c / (L + G)] : 8'($urandom);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_inta_n"}, 32'(inta_n), 32'd1);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_valid"}, 32'(vector_valid), 32'd0);
        check({tag, "_operr"}, 32'(opcode_error), 32'd0);
        check({tag, "_vtype"}, 32'(vector_type), 32'h00);
        check({tag, "_opcode"}, 32'(call_opcode), 32'h00);
        check({tag, "_addr"}, 32'(call_address), 32'h0000);
    endtask

    initial begin
        int unsigned e;
        bit          m;
        logic [7:0]  b0;

        reset_n          = 1'b1;
        interrupt        = 1'b0;
        interrupt_enable = 1'b0;
        cfg              = 1'b1;
        data_bus_in      = 8'h00;
        #1 reset_n = 1'b0;
        #1 check_reset_outputs("por");
        tick();
        tick();
        reset_n = 1'b1;

        // Request pending but interrupts disabled: no acknowledge.
        idle(20, 1'b1, 1'b0);
        idle(3, 1'b0, 1'b0);

        run_seq(1'b1, 8'hA7, 8'h5A, 8'h00, 1'b0);
        idle(3, 1'b0, 1'b0);
        run_seq(1'b0, 8'hCD, 8'h34, 8'h12, 1'b0);
        idle(2, 1'b0, 1'b0);
        run_seq(1'b0, 8'h00, 8'h78, 8'h56, 1'b0);
        idle(2, 1'b0, 1'b0);
        // Request held throughout: restart only after cooldown, back to back.
        run_seq(1'b1, 8'h11, 8'h22, 8'h33, 1'b1);
        run_seq(1'b0, 8'hCD, 8'hEF, 8'hBE, 1'b1);
        run_seq(1'b1, 8'h44, 8'h99, 8'h55, 1'b0);
        idle(2, 1'b0, 1'b0);

        for (int i = 0; i < 40; i++) begin
            m  = 1'($urandom);
            b0 = ($urandom_range(0, 1) == 0) ? 8'hCD : 8'($urandom);
            run_seq(m, b0, 8'($urandom), 8'($urandom), ($urandom_range(0, 3) == 0));
            if ($urandom_range(0, 2) != 0)
                idle($urandom_range(1, 4), 1'($urandom), 1'b0);
        end
        idle(2, 1'b0, 1'b0);

        // Reset in the second LOW phase of an 8086 sequence.
        interrupt        = 1'b1;
        interrupt_enable = 1'b1;
        cfg              = 1'b1;
        e                = cyc + 1;
        for (int unsigned c = 0; c < 4; c++)
            tl[e + c] = '{inta: (c >= L), busy: 1'b1, valid: 1'b0, operr: 1'b0};
        for (int unsigned c = 0; c < 5; c++) begin
            tick();
            interrupt   = 1'b0;
            data_bus_in = 8'($urandom);
        end
        tl[cyc] = '{inta: 1'b1, busy: 1'b0, valid: 1'b0, operr: 1'b0};
        check("pre_reset_inta_n", 32'(inta_n), 32'd0);
        #2 reset_n = 1'b0;
        m_vt   = 8'h00;
        m_op   = 8'h00;
        m_addr = 16'h0000;
        #1 check_reset_outputs("mid");
        for (int unsigned c = 0; c < 3; c++) begin
            tick();
            tl[cyc] = '{inta: 1'b1, busy: 1'b0, valid: 1'b0, operr: 1'b0};
        end
        reset_n = 1'b1;
        idle(4, 1'b0, 1'b0);
        run_seq(1'b0, 8'hCD, 8'h00, 8'h80, 1'b0);
        idle(3, 1'b0, 1'b0);
        run_seq(1'b1, 8'h00, 8'hC3, 8'h00, 1'b0);
        idle(4, 1'b0, 1'b0);

        check("pending_results", resq.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
